// File: rtl/face_scan_scheduler.sv
// face_scan_scheduler: walks a detection window over every level of an image
// pyramid, issues window coordinates to a fixed-latency Viola-Jones pipeline and
// pairs each returned verdict with the coordinates it belongs to.
// Optional build macro SCAN_STRIDE2_EN: column step of 2 instead of 1.
module face_scan_scheduler #(
  parameter int NUM_PYRAMIDS = 10,
  parameter int PIPE_LATENCY = 27,
  parameter int WIN_SIZE     = 24
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             laptop_img_rdy,
  input  logic [31:0]      pyr_width,
  input  logic [31:0]      pyr_height,
  input  logic             face_hit,
  output logic [3:0]       scan_level,
  output logic [31:0]      row_index,
  output logic [31:0]      col_index,
  output logic             win_valid,
  output logic             vj_pipeline_on,
  output logic [1:0][31:0] face_coords,
  output logic [3:0]       pyramid_number,
  output logic             face_coords_ready,
  output logic             scan_done
);

  localparam logic [31:0] WIN        = 32'(WIN_SIZE);
  localparam logic [31:0] LAST_LEVEL = 32'(NUM_PYRAMIDS - 1);
  localparam logic [31:0] DRAIN_LAST = 32'(PIPE_LATENCY);
`ifdef SCAN_STRIDE2_EN
  localparam logic [31:0] COL_STEP   = 32'd2;
`else
  localparam logic [31:0] COL_STEP   = 32'd1;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, DRAIN, DONE} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] level_q;
  logic [31:0] row_q;
  logic [31:0] col_q;
  logic [31:0] drain_q;

  logic        level_fits;
  logic [31:0] max_col;
  logic [31:0] max_row;
  logic        col_last;
  logic        row_last;
  logic        level_last;
  logic        drain_last;

  // Window coordinates travel alongside the pipeline so a verdict can be
  // matched to the window that produced it.
  logic        dl_valid [PIPE_LATENCY];
  logic [3:0]  dl_level [PIPE_LATENCY];
  logic [31:0] dl_row   [PIPE_LATENCY];
  logic [31:0] dl_col   [PIPE_LATENCY];

  // A level smaller than the window in either dimension cannot be scanned.
  assign level_fits = (pyr_width >= WIN) && (pyr_height >= WIN);
  assign max_col    = pyr_width - WIN;
  assign max_row    = pyr_height - WIN;
  assign col_last   = (col_q + COL_STEP) > max_col;
  assign row_last   = row_q >= max_row;
  assign level_last = level_q == LAST_LEVEL;
  assign drain_last = drain_q == DRAIN_LAST;

  assign scan_level     = level_q[3:0];
  assign row_index      = row_q;
  assign col_index      = col_q;
  assign win_valid      = state_q == SCAN;
  assign vj_pipeline_on = (state_q == LOAD) || (state_q == SCAN) || (state_q == DRAIN);
  assign scan_done      = state_q == DONE;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode for the frame walk.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (laptop_img_rdy) state_d = LOAD;
      LOAD: begin
        if (level_fits)      state_d = SCAN;
        else if (level_last) state_d = DRAIN;
        else                 state_d = LOAD;
      end
      SCAN: begin
        if (col_last && row_last) state_d = level_last ? DRAIN : LOAD;
      end
      DRAIN: if (drain_last) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Level, row, column and drain counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          level_q <= '0;
          row_q   <= '0;
          col_q   <= '0;
          drain_q <= '0;
        end
        LOAD: begin
          row_q <= '0;
          col_q <= '0;
          if (!level_fits && !level_last) level_q <= level_q + 32'd1;
        end
        SCAN: begin
          if (col_last) begin
            col_q <= '0;
            if (row_last) begin
              row_q <= '0;
              if (!level_last) level_q <= level_q + 32'd1;
            end else begin
              row_q <= row_q + 32'd1;
            end
          end else begin
            col_q <= col_q + COL_STEP;
          end
        end
        DRAIN: drain_q <= drain_q + 32'd1;
        DONE: begin
          level_q <= '0;
          drain_q <= '0;
        end
        default: begin
          level_q <= '0;
          row_q   <= '0;
          col_q   <= '0;
          drain_q <= '0;
        end
      endcase
    end
  end

  // Coordinate delay line, shifting every cycle with a bubble when idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        dl_valid[i] <= 1'b0;
        dl_level[i] <= '0;
        dl_row[i]   <= '0;
        dl_col[i]   <= '0;
      end
    end else begin
      dl_valid[0] <= win_valid;
      dl_level[0] <= level_q[3:0];
      dl_row[0]   <= row_q;
      dl_col[0]   <= col_q;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_level[i] <= dl_level[i-1];
        dl_row[i]   <= dl_row[i-1];
        dl_col[i]   <= dl_col[i-1];
      end
    end
  end

  // Register a face report when a verdict lines up with a real window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      face_coords_ready <= 1'b0;
      face_coords       <= '0;
      pyramid_number    <= '0;
    end else begin
      face_coords_ready <= dl_valid[PIPE_LATENCY-1] && face_hit;
      if (dl_valid[PIPE_LATENCY-1] && face_hit) begin
        face_coords[0] <= dl_row[PIPE_LATENCY-1];
        face_coords[1] <= dl_col[PIPE_LATENCY-1];
        pyramid_number <= dl_level[PIPE_LATENCY-1];
      end
    end
  end

endmodule

// File: tb/tb_face_scan_scheduler.sv
// tb_face_scan_scheduler: directed bench for face_scan_scheduler with three
// pyramid levels, pipeline latency 4 and a 24-pixel window.
// Honours SCAN_STRIDE2_EN for its expected window counts.
module tb_face_scan_scheduler;

  localparam int NP  = 3;
  localparam int LAT = 4;
  localparam int WS  = 24;

`ifdef SCAN_STRIDE2_EN
  localparam int TGT_COL  = 2;
  localparam int TGT_OFF  = 5;
  localparam int DONE_OFF = 13;
  localparam int WIN26    = 4;
`else
  localparam int TGT_COL  = 1;
  localparam int TGT_OFF  = 6;
  localparam int DONE_OFF = 15;
  localparam int WIN26    = 6;
`endif

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             laptop_img_rdy = 1'b0;
  logic [31:0]      pyr_width;
  logic [31:0]      pyr_height;
  logic             face_hit = 1'b0;
  logic [3:0]       scan_level;
  logic [31:0]      row_index;
  logic [31:0]      col_index;
  logic             win_valid;
  logic             vj_pipeline_on;
  logic [1:0][31:0] face_coords;
  logic [3:0]       pyramid_number;
  logic             face_coords_ready;
  logic             scan_done;

  logic [31:0] dim_w [NP];
  logic [31:0] dim_h [NP];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  int win_cnt, ready_cnt, done_cnt, done_cyc;
  int lvl_cnt [NP];
  int first_win_cyc, first_row, first_col, first_lvl;
  int ready_cyc, ready_row, ready_col, ready_pyr;
  int vj_first, vj_last, target_cyc;

  typedef struct {
    int w0; int h0; int w1; int h1; int w2; int h2;
    bit hit_all;
    int exp_l0; int exp_l1; int exp_l2;
  } vec_t;

  vec_t vecs [4];

  face_scan_scheduler #(
    .NUM_PYRAMIDS(NP),
    .PIPE_LATENCY(LAT),
    .WIN_SIZE(WS)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .laptop_img_rdy(laptop_img_rdy),
    .pyr_width(pyr_width),
    .pyr_height(pyr_height),
    .face_hit(face_hit),
    .scan_level(scan_level),
    .row_index(row_index),
    .col_index(col_index),
    .win_valid(win_valid),
    .vj_pipeline_on(vj_pipeline_on),
    .face_coords(face_coords),
    .pyramid_number(pyramid_number),
    .face_coords_ready(face_coords_ready),
    .scan_done(scan_done)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Cycle number used to time every event.
  always @(posedge clock) cyc <= cyc + 1;

  // Combinational pyramid dimension lookup.
  always_comb begin
    pyr_width  = '0;
    pyr_height = '0;
    case (scan_level)
      4'd0: begin pyr_width = dim_w[0]; pyr_height = dim_h[0]; end
      4'd1: begin pyr_width = dim_w[1]; pyr_height = dim_h[1]; end
      4'd2: begin pyr_width = dim_w[2]; pyr_height = dim_h[2]; end
      default: ;
    endcase
  end

  // Observe DUT outputs mid-cycle and log windows, reports and busy span.
  always @(negedge clock) begin
    if (win_valid) begin
      if (win_cnt == 0) begin
        first_win_cyc = cyc;
        first_row     = int'(row_index);
        first_col     = int'(col_index);
        first_lvl     = int'(scan_level);
      end
      win_cnt++;
      if (int'(scan_level) < NP) lvl_cnt[int'(scan_level)]++;
      if (scan_level == 4'd0 && int'(row_index) == 1 && int'(col_index) == TGT_COL)
        target_cyc = cyc;
    end
    if (face_coords_ready) begin
      ready_cnt++;
      ready_cyc = cyc;
      ready_row = int'(face_coords[0]);
      ready_col = int'(face_coords[1]);
      ready_pyr = int'(pyramid_number);
    end
    if (scan_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (vj_pipeline_on) begin
      if (vj_first < 0) vj_first = cyc;
      vj_last = cyc;
    end
  end

  task automatic clear_monitor();
    win_cnt = 0; ready_cnt = 0; done_cnt = 0; done_cyc = -1;
    for (int i = 0; i < NP; i++) lvl_cnt[i] = 0;
    first_win_cyc = -1; first_row = -1; first_col = -1; first_lvl = -1;
    ready_cyc = -1; ready_row = -1; ready_col = -1; ready_pyr = -1;
    vj_first = -1; vj_last = -1; target_cyc = -1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic set_dims(input int w0, input int h0, input int w1, input int h1,
                          input int w2, input int h2);
    dim_w[0] = 32'(w0); dim_h[0] = 32'(h0);
    dim_w[1] = 32'(w1); dim_h[1] = 32'(h1);
    dim_w[2] = 32'(w2); dim_h[2] = 32'(h2);
  endtask

  task automatic pulse_start(output int s);
    @(posedge clock); #1;
    laptop_img_rdy = 1'b1;
    s = cyc;
    @(posedge clock); #1;
    laptop_img_rdy = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("scan_done_seen", done_cnt, 1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int idx);
    int s;
    int sum;
    set_dims(vecs[idx].w0, vecs[idx].h0, vecs[idx].w1, vecs[idx].h1,
             vecs[idx].w2, vecs[idx].h2);
    face_hit = vecs[idx].hit_all;
    clear_monitor();
    pulse_start(s);
    wait_done(500);
    face_hit = 1'b0;
    sum = vecs[idx].exp_l0 + vecs[idx].exp_l1 + vecs[idx].exp_l2;
    checkOutput($sformatf("vec%0d_level0_windows", idx), lvl_cnt[0], vecs[idx].exp_l0);
    checkOutput($sformatf("vec%0d_level1_windows", idx), lvl_cnt[1], vecs[idx].exp_l1);
    checkOutput($sformatf("vec%0d_level2_windows", idx), lvl_cnt[2], vecs[idx].exp_l2);
    checkOutput($sformatf("vec%0d_total_windows", idx), win_cnt, sum);
    checkOutput($sformatf("vec%0d_reports", idx), ready_cnt, vecs[idx].hit_all ? sum : 0);
    checkOutput($sformatf("vec%0d_busy_after", idx), int'(vj_pipeline_on), 0);
  endtask

  // Backstop so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence.
  initial begin
    int s;

`ifdef SCAN_STRIDE2_EN
    vecs[0] = '{w0:26, h0:25, w1:20, h1:20, w2:20, h2:20, hit_all:1'b0, exp_l0:4, exp_l1:0, exp_l2:0};
    vecs[1] = '{w0:26, h0:25, w1:20, h1:30, w2:25, h2:24, hit_all:1'b1, exp_l0:4, exp_l1:0, exp_l2:1};
    vecs[2] = '{w0:27, h0:24, w1:24, h1:24, w2:30, h2:20, hit_all:1'b1, exp_l0:2, exp_l1:1, exp_l2:0};
`else
    vecs[0] = '{w0:26, h0:25, w1:20, h1:20, w2:20, h2:20, hit_all:1'b0, exp_l0:6, exp_l1:0, exp_l2:0};
    vecs[1] = '{w0:26, h0:25, w1:20, h1:30, w2:25, h2:24, hit_all:1'b1, exp_l0:6, exp_l1:0, exp_l2:2};
    vecs[2] = '{w0:27, h0:24, w1:24, h1:24, w2:30, h2:20, hit_all:1'b1, exp_l0:4, exp_l1:1, exp_l2:0};
`endif
    vecs[3] = '{w0:24, h0:26, w1:20, h1:20, w2:24, h2:24, hit_all:1'b0, exp_l0:3, exp_l1:0, exp_l2:1};

    set_dims(26, 25, 20, 20, 20, 20);
    clear_monitor();
    #2;
    checkOutput("reset_win_valid", int'(win_valid), 0);
    checkOutput("reset_busy", int'(vj_pipeline_on), 0);
    checkOutput("reset_ready", int'(face_coords_ready), 0);
    checkOutput("reset_scan_done", int'(scan_done), 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < 4; i++) applyStimulus(i);

    // Single report timing, with stray verdicts while idle ignored.
    set_dims(26, 25, 20, 20, 20, 20);
    clear_monitor();
    face_hit = 1'b1;
    repeat (3) @(posedge clock);
    #1 face_hit = 1'b0;
    pulse_start(s);
    while (cyc < s + TGT_OFF + LAT) begin
      @(posedge clock); #1;
    end
    face_hit = 1'b1;
    @(posedge clock); #1;
    face_hit = 1'b0;
    wait_done(200);
    checkOutput("timing_first_window_cycle", first_win_cyc - s, 2);
    checkOutput("timing_target_issue_cycle", target_cyc - s, TGT_OFF);
    checkOutput("timing_report_count", ready_cnt, 1);
    checkOutput("timing_report_cycle", ready_cyc - s, TGT_OFF + LAT + 1);
    checkOutput("timing_report_row", ready_row, 1);
    checkOutput("timing_report_col", ready_col, TGT_COL);
    checkOutput("timing_report_level", ready_pyr, 0);
    checkOutput("timing_done_cycle", done_cyc - s, DONE_OFF);
    checkOutput("timing_busy_first", vj_first - s, 1);
    checkOutput("timing_busy_last", vj_last - s, DONE_OFF - 1);

    // Asynchronous reset in the middle of a scan with verdicts streaming.
    set_dims(30, 30, 20, 20, 20, 20);
    clear_monitor();
    face_hit = 1'b1;
    pulse_start(s);
    while (cyc < s + 8) begin
      @(posedge clock); #1;
    end
    checkOutput("midscan_reports_before_reset", ready_cnt, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midreset_win_valid", int'(win_valid), 0);
    checkOutput("midreset_busy", int'(vj_pipeline_on), 0);
    checkOutput("midreset_ready", int'(face_coords_ready), 0);
    checkOutput("midreset_row", int'(row_index), 0);
    checkOutput("midreset_col", int'(col_index), 0);
    checkOutput("midreset_coords_row", int'(face_coords[0]), 0);
    clear_monitor();
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (LAT + 4) @(posedge clock);
    #1;
    checkOutput("postreset_late_reports", ready_cnt, 0);
    checkOutput("postreset_windows", win_cnt, 0);
    face_hit = 1'b0;
    set_dims(26, 25, 20, 20, 20, 20);
    clear_monitor();
    pulse_start(s);
    wait_done(200);
    checkOutput("restart_first_level", first_lvl, 0);
    checkOutput("restart_first_row", first_row, 0);
    checkOutput("restart_first_col", first_col, 0);
    checkOutput("restart_first_cycle", first_win_cyc - s, 2);
    checkOutput("restart_windows", win_cnt, WIN26);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
